xclk_strobe_sched: RTL and testbench

Schedules strobe events from N requesters in the `in_clk` domain onto one shared, acknowledged toggle crossing into the `out_clk` domain. The crossing delivers a single-cycle `out_stb` plus the requester index `out_id`. Pending requests are held per requester and served round-robin. A new event is launched only after the previous toggle has been echoed back, so the crossing never sees toggles closer than its round-trip time. The block sits between event sources (for example, status or interrupt pulses) and a slower or unrelated-clock consumer.

---
 rtl/xclk_strobe_sched_pkg.sv | 19 +
 rtl/xclk_toggle_sync.sv | 40 ++++
 rtl/xclk_strobe_sched.sv | 152 +++++++++++++++
 tb/tb_xclk_strobe_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xclk_strobe_sched_pkg.sv
// ---------------------------------------------------------------------------
// xclk_strobe_sched_pkg
// Shared types for the cross-clock strobe scheduler.
//   state_e : source-domain FSM state (IDLE / WAIT_ACK), 1-bit encoding.
// ---------------------------------------------------------------------------
package xclk_strobe_sched_pkg;

  // Source-side launch FSM. WAIT_ACK means one toggle is in flight on the
  // shared crossing and its echo has not returned yet.
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_e;

  // Legal range of the requester count.
  localparam int MIN_REQ = 2;
  localparam int MAX_REQ = 16;

endpackage : xclk_strobe_sched_pkg

// File: rtl/xclk_toggle_sync.sv
// ---------------------------------------------------------------------------
// xclk_toggle_sync
// Two-flop synchroniser for a level/toggle signal, with async reset.
// Ports:
//   clk   in  destination clock
//   rst   in  asynchronous, active-high reset
//   i_d   in  level from the foreign clock domain
//   o_s0  out first (metastability-settling) stage
//   o_s1  out second stage, safe to use as a synchronous level
// ---------------------------------------------------------------------------
module xclk_toggle_sync
  import xclk_strobe_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_s0,
  output logic o_s1
);

  logic r_s0;
  logic r_s1;

  // NOTE: flops with an asynchronous reset list the reset edge in the
  // sensitivity list; every branch uses non-blocking assignments so all
  // stages sample their inputs from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= i_d;
      r_s1 <= r_s0;
    end
  end

  assign o_s0 = r_s0;
  assign o_s1 = r_s1;

endmodule : xclk_toggle_sync

// File: rtl/xclk_strobe_sched.sv
// ---------------------------------------------------------------------------
// xclk_strobe_sched
// Collects single-cycle strobes from N requesters (in_clk domain), serves
// them round-robin, and ships one event at a time over an acknowledged
// toggle crossing into the out_clk domain.
// Ports:
//   in_clk    in  source clock (i_req, o_pend, o_busy, o_ovr)
//   out_clk   in  destination clock (o_out_stb, o_out_id)
//   rst       in  asynchronous, active-high reset for both domains
//   i_req     in  N     per-requester single-cycle strobe
//   o_pend    out N     captured requests not yet launched
//   o_busy    out 1     event in flight, echo not yet returned
//   o_ovr     out 1     pulse: a request merged into a pending one
//   o_out_stb out 1     one out_clk cycle per delivered event
//   o_out_id  out ID_W  requester index, held between strobes
// ---------------------------------------------------------------------------
module xclk_strobe_sched
  import xclk_strobe_sched_pkg::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic            in_clk,
  input  logic            out_clk,
  input  logic            rst,
  input  logic [N-1:0]    i_req,
  output logic [N-1:0]    o_pend,
  output logic            o_busy,
  output logic            o_ovr,
  output logic            o_out_stb,
  output logic [ID_W-1:0] o_out_id
);

  // ---------------- source domain ----------------
  state_e          r_state;
  state_e          w_state_nxt;
  logic [N-1:0]    r_pend;
  logic [N-1:0]    w_pend_nxt;
  logic [N-1:0]    w_clr;
  logic            r_ovr;
  logic            w_ovr_nxt;
  logic            r_src;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] r_last;
  logic [ID_W-1:0] w_pick;
  logic            w_grant;
  logic            w_a0_unused;
  logic            w_a1;

  // ---------------- destination domain ----------------
  logic            w_s0;
  logic            w_s1;
  logic            r_out_stb;
  logic [ID_W-1:0] r_out_id;
  logic            r_ack;

  // First set bit of pend, scanning upward from last+1 with wrap.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0]    pend,
                                              input logic [ID_W-1:0] last);
    logic found;
    int   j;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last) + k) % N;
      if (!found && pend[j]) begin
        rr_pick = ID_W'(j);
        found   = 1'b1;
      end
    end
  endfunction

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_grant     = (r_state == ST_IDLE) && (|r_pend);
    w_pick      = rr_pick(r_pend, r_last);
    w_clr       = w_grant ? (N'(1) << w_pick) : '0;
    // A request landing on the bit being granted refills it without an
    // overflow; only a truly occupied slot counts as a merge.
    w_pend_nxt  = (r_pend & ~w_clr) | i_req;
    w_ovr_nxt   = |(i_req & r_pend & ~w_clr);
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_grant)       w_state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: if (w_a1 == r_src) w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_ovr  <= 1'b0;
      r_src  <= 1'b0;
      r_id   <= '0;
      r_last <= ID_W'(N - 1);   // requester 0 wins the first scan
    end else begin
      r_pend <= w_pend_nxt;
      r_ovr  <= w_ovr_nxt;
      if (w_grant) begin
        r_id   <= w_pick;
        r_last <= w_pick;
        r_src  <= ~r_src;
      end
    end
  end

  // Forward crossing: src toggle into out_clk.
  xclk_toggle_sync u_fwd_sync (
    .clk  (out_clk),
    .rst  (rst),
    .i_d  (r_src),
    .o_s0 (w_s0),
    .o_s1 (w_s1)
  );

  // r_id is read here unsynchronised: it only changes on a grant, which
  // happens in IDLE, i.e. never while a toggle is being received.
  always_ff @(posedge out_clk or posedge rst) begin
    if (rst) begin
      r_out_stb <= 1'b0;
      r_out_id  <= '0;
      r_ack     <= 1'b0;
    end else begin
      r_out_stb <= w_s0 ^ w_s1;
      if (w_s0 ^ w_s1) r_out_id <= r_id;
      r_ack     <= w_s1;
    end
  end

  // Reverse crossing: echo back into in_clk. Only the settled stage is used.
  xclk_toggle_sync u_ack_sync (
    .clk  (in_clk),
    .rst  (rst),
    .i_d  (r_ack),
    .o_s0 (w_a0_unused),
    .o_s1 (w_a1)
  );

  assign o_pend    = r_pend;
  assign o_busy    = (r_state == ST_WAIT_ACK);
  assign o_ovr     = r_ovr;
  assign o_out_stb = r_out_stb;
  assign o_out_id  = r_out_id;

endmodule : xclk_strobe_sched

// File: tb/tb_xclk_strobe_sched.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_xclk_strobe_sched
// Source side: a behavioural model (pending set, last winner, idle flag)
// predicts pend/ovr/busy each in_clk cycle and pushes every launched id into
// a scoreboard queue. Destination side: a monitor pops the queue on every
// out_stb and compares out_id, and checks out_id holds between strobes.
// ---------------------------------------------------------------------------
module tb_xclk_strobe_sched;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            in_clk  = 1'b0;
  logic            out_clk = 1'b0;
  logic            rst     = 1'b1;
  logic [N-1:0]    i_req   = '0;
  logic [N-1:0]    o_pend;
  logic            o_busy;
  logic            o_ovr;
  logic            o_out_stb;
  logic [ID_W-1:0] o_out_id;

  real out_half = 5.0;

  xclk_strobe_sched #(.N(N)) dut (
    .in_clk    (in_clk),
    .out_clk   (out_clk),
    .rst       (rst),
    .i_req     (i_req),
    .o_pend    (o_pend),
    .o_busy    (o_busy),
    .o_ovr     (o_ovr),
    .o_out_stb (o_out_stb),
    .o_out_id  (o_out_id)
  );

  initial forever #5 in_clk = ~in_clk;
  initial forever #(out_half) out_clk = ~out_clk;

  // ---------------- model / scoreboard state ----------------
  logic [N-1:0] m_pend   = '0;
  int           m_last   = N - 1;
  bit           m_idle   = 1'b1;
  int           wait_cnt = 0;
  int           sb_q[$];
  int           mon_last = 0;
  int           n_vec    = 0;
  int           n_err    = 0;
  int           n_stb    = 0;
  int           n_grant  = 0;
  int           n_ovr    = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first pending requester after the last winner.
  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      if (m_pend[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  // One in_clk cycle with request vector r, then compare at the falling edge.
  task automatic step(input logic [N-1:0] r);
    bit           grant;
    int           idx;
    logic [N-1:0] clr;
    logic         exp_ovr;
    bit           was_idle;
    i_req = r;
    @(posedge in_clk);
    was_idle = m_idle;
    grant    = m_idle && (m_pend != '0);
    clr      = '0;
    idx      = 0;
    if (grant) begin
      idx      = model_pick();
      clr[idx] = 1'b1;
      sb_q.push_back(idx);
      m_last   = idx;
      m_idle   = 1'b0;
      wait_cnt = 0;
      n_grant++;
    end
    exp_ovr = |(r & m_pend & ~clr);
    m_pend  = (m_pend & ~clr) | r;
    @(negedge in_clk);
    check("pend", 32'(o_pend), 32'(m_pend));
    check("ovr", 32'(o_ovr), 32'(exp_ovr));
    if (o_ovr) n_ovr++;
    if (grant) begin
      check("busy_on_grant", 32'(o_busy), 32'd1);
    end else if (was_idle) begin
      check("busy_idle", 32'(o_busy), 32'd0);
    end else if (!o_busy) begin
      m_idle = 1'b1;              // echo returned; crossing free again
    end else begin
      wait_cnt++;
      if (wait_cnt > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL ack_timeout: busy still 1 after %0d cycles, expected 0", wait_cnt);
        m_idle = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int budget = 0;
    while (!(m_pend == '0 && m_idle && sb_q.size() == 0)) begin
      if (budget == 4000) begin
        n_vec++;
        n_err++;
        $display("FAIL drain_timeout: %0d ids still queued, pend=%0h, expected empty",
                 sb_q.size(), m_pend);
        sb_q.delete();
        m_idle = 1'b1;
        return;
      end
      budget++;
      step('0);
    end
    repeat (4) step('0);
  endtask

  task automatic apply_reset();
    @(negedge in_clk);
    rst      = 1'b1;
    i_req    = '0;
    m_pend   = '0;
    m_last   = N - 1;
    m_idle   = 1'b1;
    wait_cnt = 0;
    sb_q.delete();
    mon_last = 0;
    #2;
    check("rst_pend", 32'(o_pend), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ovr", 32'(o_ovr), 32'd0);
    check("rst_stb", 32'(o_out_stb), 32'd0);
    check("rst_id", 32'(o_out_id), 32'd0);
    @(negedge in_clk);
    @(negedge in_clk);
    rst = 1'b0;
  endtask

  // ---------------- destination-side monitor ----------------
  initial begin
    int exp_id;
    forever begin
      @(negedge out_clk);
      if (!rst) begin
        if (o_out_stb) begin
          n_stb++;
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_stb: out_id=%0d, expected no strobe", o_out_id);
          end else begin
            exp_id   = sb_q.pop_front();
            check("out_id", 32'(o_out_id), 32'(exp_id));
            mon_last = exp_id;
          end
        end else begin
          check("out_id_hold", 32'(o_out_id), 32'(mon_last));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int   s_stb;
    int   s_ovr;
    int   s_grant;
    real  ratios[3];
    logic [N-1:0] r;
    ratios[0] = 0.13;
    ratios[1] = 1.0;
    ratios[2] = 3.7;

    out_half = 5.0 / 0.37;

    // Single request from requester 2.
    apply_reset();
    s_stb = n_stb;
    step(4'b0100);
    drain();
    check("single_stb_count", 32'(n_stb - s_stb), 32'd1);
    check("single_pend", 32'(o_pend), 32'd0);
    check("single_busy", 32'(o_busy), 32'd0);

    // All four at once: ids 0,1,2,3 in order, no merges.
    apply_reset();
    s_stb = n_stb;
    s_ovr = n_ovr;
    step(4'b1111);
    drain();
    check("rr_stb_count", 32'(n_stb - s_stb), 32'd4);
    check("rr_ovr_count", 32'(n_ovr - s_ovr), 32'd0);

    // Requester 1 hits three times while requester 0 is in flight.
    apply_reset();
    s_stb = n_stb;
    s_ovr = n_ovr;
    step(4'b0001);
    step(4'b0000);
    step(4'b0010);
    step(4'b0010);
    step(4'b0010);
    drain();
    check("coalesce_ovr_count", 32'(n_ovr - s_ovr), 32'd2);
    check("coalesce_stb_count", 32'(n_stb - s_stb), 32'd2);

    // Re-request of requester 0 on its own grant edge.
    apply_reset();
    s_stb = n_stb;
    s_ovr = n_ovr;
    step(4'b0001);
    step(4'b0001);
    drain();
    check("regrant_stb_count", 32'(n_stb - s_stb), 32'd2);
    check("regrant_ovr_count", 32'(n_ovr - s_ovr), 32'd0);

    // Reset while an event is in flight: it must vanish.
    apply_reset();
    step(4'b0001);
    step(4'b0000);
    apply_reset();
    s_stb = n_stb;
    repeat (20) step('0);
    check("postrst_no_stb", 32'(n_stb - s_stb), 32'd0);
    step(4'b1111);
    drain();
    check("postrst_stb_count", 32'(n_stb - s_stb), 32'd4);

    // Random traffic at three clock ratios.
    foreach (ratios[i]) begin
      out_half = 5.0 / ratios[i];
      apply_reset();
      s_stb   = n_stb;
      s_grant = n_grant;
      repeat (300) begin
        for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 5) == 0);
        step(r);
      end
      drain();
      check("rand_grant_vs_stb", 32'(n_stb - s_stb), 32'(n_grant - s_grant));
      check("rand_sb_empty", 32'(sb_q.size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_xclk_strobe_sched
